player_shot_ctrl: RTL
=====================

Name: player_shot_ctrl

Overview:
- Sequences the single player missile: launches it from the current player position on a fire press, advances it once per frame, and ends it on a hit or at the top of the playfield.
- Holds an explosion phase and a reload cooldown before the next shot is allowed.
- Sits between the button inputs / player position logic and the renderer and collision logic.
- Upstream collision logic reports hits. Downstream renderer and sound logic consume the shot position and status.

Parameters:
- SPRITE_W, 32, scaled player sprite width in pixels; used for shot centring.
- SHOT_W, 2, shot width in pixels.
- SHOT_H, 8, shot height in pixels.
- SHOT_STEP, 4, pixels moved upward per frame.
- TOP_Y, 16, topmost legal shot_y.
- EXPLODE_FRAMES, 8, frames spent in BOOM.
- COOLDOWN_FRAMES, 4, frames spent in COOL; 0 means skip COOL.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- arst  in  1  asynchronous active-high reset (game restart); ORed with rst.
- frame  in  1  one-clk pulse per video frame.
- fire  in  1  fire button level, already synchronised.
- player_x  in  10  player sprite left edge.
- player_y  in  10  player sprite top edge.
- hit  in  1  collision pulse from collision logic; any cycle.
- shot_x  out  10  shot left edge.
- shot_y  out  10  shot top edge.
- shot_active  out  1  shot is flying; renderer draws the shot.
- shot_boom  out  1  explosion sprite is drawn at shot_x/shot_y.
- shot_fired  out  1  one-clk pulse on launch (sound trigger).
- shot_top  out  1  set when the last shot ended at the top, not by a hit; held until the next launch.

Behaviour:
- Reset (rst or arst high, asynchronous):
  - State is IDLE.
  - shot_x, shot_y are 0.
  - shot_active, shot_boom, shot_fired, shot_top are 0.
  - Fire-pending, hit-latch and timer are cleared.
  - Reset asserted mid-flight or mid-BOOM kills the shot immediately.
- Fire edge detection:
  - fire_q is registered every clk.
  - A rising edge (fire & ~fire_q) sets pend.
  - Holding fire never auto-repeats; fire must be released before it can trigger again.
- pend handling:
  - pend is cleared on every frame pulse, whether or not it is used.
  - A press made while a shot is in flight, in BOOM or in COOL is therefore dropped.
- All state and position updates occur only on the clk where frame=1. shot_fired is the only exception, pulsing on that same clk.
- State machine (transitions evaluated on the frame clk):
  - IDLE:
    - If pend, go to FLY.
    - shot_x = player_x + SPRITE_W/2 - SHOT_W/2.
    - shot_y = player_y - SHOT_H.
    - shot_active=1, shot_fired=1 for one clk, shot_top=0.
  - FLY:
    - If hit_latch, go to BOOM; shot_top=0.
    - Else if shot_y < TOP_Y + SHOT_STEP, go to BOOM; shot_top=1.
    - Else shot_y = shot_y - SHOT_STEP.
    - On entry to BOOM: shot_active=0, shot_boom=1, timer=EXPLODE_FRAMES-1. shot_x/shot_y are frozen.
  - BOOM:
    - If timer==0, clear shot_boom. Go to COOL with timer=COOLDOWN_FRAMES-1, or go to IDLE if COOLDOWN_FRAMES==0.
    - Else decrement timer.
  - COOL:
    - If timer==0, go to IDLE.
    - Else decrement timer.
- hit latch:
  - Set by hit only while state==FLY.
  - Cleared on leaving FLY.
  - hit outside FLY is ignored.
  - hit on the same clk as frame in FLY counts for that frame.
- Hit and top on the same frame: hit wins, so shot_top=0.
- Arithmetic:
  - Positions are 10-bit unsigned.
  - The launch subtraction wraps if player_y < SHOT_H. Callers guarantee player_y >= SHOT_H.
  - The top check prevents wrap in flight.
- Timer width: clog2 of max(EXPLODE_FRAMES, COOLDOWN_FRAMES), minimum 1 bit.
- Latency:
  - A press lands on the next frame pulse.
  - The first visible shot appears in that frame.

Decomposition:
- Shared constants:
  - State encodings (IDLE=0, FLY=1, BOOM=2, COOL=3).
  - SHOT_W, SHOT_H, SHOT_STEP, TOP_Y.
  - These live in util/constants.v next to the existing player/sprite constants. Parameters default to those values.
- Sub-module:
  - One natural sub-module, edge_detect (fire rising edge, clk/rst/arst).
  - It is reusable for the pause and start buttons.
  - The FSM and timer stay inline.

Test Plan:
- Launch: player_x=300, player_y=440, fire rises, one frame later.
  - Response: shot_x=315, shot_y=432, shot_active=1, shot_fired high exactly 1 clk.
- Flight to top: no hits after the launch above.
  - Frame k gives shot_y=432-4k; frame 104 gives 16.
  - Frame 105: shot_boom=1, shot_top=1, shot_active=0.
  - 8 frames later: shot_boom=0.
  - 4 frames after that: IDLE.
- Hit: hit pulse mid-cycle while shot_y=400; next frame gives BOOM, shot_top=0, shot_y held at 400.
  - Also assert hit coincident with frame; required response: BOOM on that frame.
- Fire during FLY/BOOM/COOL, and fire held high through return to IDLE: no launch.
  - Release, then press: launch on the next frame.
- Hit outside FLY:
  - hit while IDLE is ignored; a subsequent launch flies normally.
  - hit and top condition on the same frame gives shot_top=0.
- Reset mid-flight:
  - Assert arst asynchronously (no clk edge) at shot_y=200.
  - Response: all outputs 0 immediately, state IDLE.
  - After release, a fire press launches normally.

Source files
------------

// File: rtl/player_shot_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the player missile
// sequencer and its reusable button edge detector.
package player_shot_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_BOOM = 2'd2,
        ST_COOL = 2'd3
    } shot_state_e;

    localparam int POS_W               = 10;
    localparam int SPRITE_W_DEF        = 32;
    localparam int SHOT_W_DEF          = 2;
    localparam int SHOT_H_DEF          = 8;
    localparam int SHOT_STEP_DEF       = 4;
    localparam int TOP_Y_DEF           = 16;
    localparam int EXPLODE_FRAMES_DEF  = 8;
    localparam int COOLDOWN_FRAMES_DEF = 4;

    // Frame timer width: clog2 of the longer phase, never narrower than 1 bit.
    function automatic int timer_width(input int explode_frames, input int cooldown_frames);
        int longest;
        longest = (explode_frames > cooldown_frames) ? explode_frames : cooldown_frames;
        return ($clog2(longest) < 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/player_shot_ctrl_if.sv
// Bundle of frame/button/position inputs and shot status outputs between the
// game logic (master) and the shot sequencer (slave).
interface player_shot_ctrl_if;
    import player_shot_ctrl_pkg::*;

    logic             frame;
    logic             fire;
    logic [POS_W-1:0] player_x;
    logic [POS_W-1:0] player_y;
    logic             hit;
    logic [POS_W-1:0] shot_x;
    logic [POS_W-1:0] shot_y;
    logic             shot_active;
    logic             shot_boom;
    logic             shot_fired;
    logic             shot_top;

    modport master (
        output frame, fire, player_x, player_y, hit,
        input  shot_x, shot_y, shot_active, shot_boom, shot_fired, shot_top
    );

    modport slave (
        input  frame, fire, player_x, player_y, hit,
        output shot_x, shot_y, shot_active, shot_boom, shot_fired, shot_top
    );

endinterface

// File: rtl/player_shot_ctrl_edge_detect.sv
// Rising-edge detector for an already-synchronised button level; shared by the
// fire, pause and start buttons.
module player_shot_ctrl_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic arst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Previous button level
    always_ff @(posedge clk or posedge rst or posedge arst) begin
        if (rst || arst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/player_shot_ctrl.sv
// Player missile sequencer: launch on a pending fire press, climb once per frame,
// explode on hit or at the playfield top, then cool down before re-arming.
module player_shot_ctrl
    import player_shot_ctrl_pkg::*;
#(
    parameter int SPRITE_W        = SPRITE_W_DEF,
    parameter int SHOT_W          = SHOT_W_DEF,
    parameter int SHOT_H          = SHOT_H_DEF,
    parameter int SHOT_STEP       = SHOT_STEP_DEF,
    parameter int TOP_Y           = TOP_Y_DEF,
    parameter int EXPLODE_FRAMES  = EXPLODE_FRAMES_DEF,
    parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arst,
    player_shot_ctrl_if.slave bus
);

    localparam int               TW        = timer_width(EXPLODE_FRAMES, COOLDOWN_FRAMES);
    localparam logic [TW-1:0]    EXP_LOAD  = TW'(EXPLODE_FRAMES - 1);
    localparam logic [TW-1:0]    COOL_LOAD = TW'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
    localparam logic [POS_W-1:0] X_OFS     = POS_W'(SPRITE_W / 2 - SHOT_W / 2);
    localparam logic [POS_W-1:0] Y_OFS     = POS_W'(SHOT_H);
    localparam logic [POS_W-1:0] STEP      = POS_W'(SHOT_STEP);
    localparam logic [POS_W-1:0] TOP_LIM   = POS_W'(TOP_Y + SHOT_STEP);

    shot_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pend_q, pend_d;
    logic             hit_latch_q, hit_latch_d;
    logic [POS_W-1:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;
    logic             active_q, active_d, boom_q, boom_d;
    logic             fired_q, fired_d, top_q, top_d;
    logic             fire_rise_s, hit_now_s, at_top_s;

    player_shot_ctrl_edge_detect u_fire_edge (
        .clk    (clk),
        .rst    (rst),
        .arst   (arst),
        .d_i    (bus.fire),
        .rise_o (fire_rise_s)
    );

    // A hit arriving on the frame clk itself still counts for that frame.
    assign hit_now_s = hit_latch_q | bus.hit;
    assign at_top_s  = (shot_y_q < TOP_LIM);

    // State, timer, latches and registered outputs
    always_ff @(posedge clk or posedge rst or posedge arst) begin
        if (rst || arst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            hit_latch_q <= 1'b0;
            shot_x_q    <= '0;
            shot_y_q    <= '0;
            active_q    <= 1'b0;
            boom_q      <= 1'b0;
            fired_q     <= 1'b0;
            top_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            hit_latch_q <= hit_latch_d;
            shot_x_q    <= shot_x_d;
            shot_y_q    <= shot_y_d;
            active_q    <= active_d;
            boom_q      <= boom_d;
            fired_q     <= fired_d;
            top_q       <= top_d;
        end
    end

    // Next state, phase timer, fire-pending and hit latch
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (bus.frame) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        state_d = ST_FLY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLY: begin
                    if (hit_now_s || at_top_s) begin
                        state_d = ST_BOOM;
                        timer_d = EXP_LOAD;
                    end else begin
                        state_d = ST_FLY;
                    end
                end
                ST_BOOM: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else if (COOLDOWN_FRAMES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COOL;
                        timer_d = COOL_LOAD;
                    end
                end
                ST_COOL: begin
                    if (timer_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Every frame consumes the pending press, so presses outside IDLE are lost.
        pend_d      = fire_rise_s | (pend_q & ~bus.frame);
        hit_latch_d = (state_q == ST_FLY) && (state_d == ST_FLY) && hit_now_s;
    end

    // Next values of the shot position and status outputs
    always_comb begin
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;
        active_d = active_q;
        boom_d   = boom_q;
        fired_d  = 1'b0;
        top_d    = top_q;
        if (bus.frame) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        shot_x_d = bus.player_x + X_OFS;
                        shot_y_d = bus.player_y - Y_OFS;
                        active_d = 1'b1;
                        fired_d  = 1'b1;
                        top_d    = 1'b0;
                    end else begin
                        active_d = 1'b0;
                    end
                end
                ST_FLY: begin
                    if (hit_now_s || at_top_s) begin
                        active_d = 1'b0;
                        boom_d   = 1'b1;
                        top_d    = ~hit_now_s;
                    end else begin
                        shot_y_d = shot_y_q - STEP;
                    end
                end
                ST_BOOM: begin
                    if (timer_q == '0) begin
                        boom_d = 1'b0;
                    end else begin
                        boom_d = 1'b1;
                    end
                end
                ST_COOL: begin
                    boom_d = 1'b0;
                end
                default: begin
                    active_d = 1'b0;
                    boom_d   = 1'b0;
                end
            endcase
        end else begin
            fired_d = 1'b0;
        end
    end

    assign bus.shot_x      = shot_x_q;
    assign bus.shot_y      = shot_y_q;
    assign bus.shot_active = active_q;
    assign bus.shot_boom   = boom_q;
    assign bus.shot_fired  = fired_q;
    assign bus.shot_top    = top_q;

endmodule
